// File: rtl/io_bus_decoder_if.sv
// io_bus_decoder_if: CPU-side bus bundle between the 68k and the I/O decoder.
// Parameter: NUM_CH - number of decoded peripheral channels (enable width).
// Signals:
//   i_address[31:0]  68k address bus (decoder uses [15:4])
//   i_io_select_h    high when the CPU address is in the 0040_xxxx I/O window
//   i_as_l           68k address strobe, active low
//   o_enable_h       one-hot registered channel enable
//   o_dtack_l        data-transfer acknowledge, active low
//   o_berr_l         bus error, active low
//   o_busy_h         decoder FSM not idle
// Modports: master drives the request side, slave (the decoder) drives the response side.
interface io_bus_decoder_if #(
  parameter int NUM_CH = 4
);
  logic [31:0]       i_address;
  logic              i_io_select_h;
  logic              i_as_l;
  logic [NUM_CH-1:0] o_enable_h;
  logic              o_dtack_l;
  logic              o_berr_l;
  logic              o_busy_h;
  modport master (
    output i_address, i_io_select_h, i_as_l,
    input  o_enable_h, o_dtack_l, o_berr_l, o_busy_h
  );
  modport slave (
    input  i_address, i_io_select_h, i_as_l,
    output o_enable_h, o_dtack_l, o_berr_l, o_busy_h
  );
endinterface

// File: rtl/io_bus_decoder.sv
// io_bus_decoder: 68k I/O address decoder with per-channel wait states and optional bus-error timeout.
// Ports:
//   i_clk    system clock, all state changes on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      io_bus_decoder_if.slave (address/select/strobe in; enable/dtack/berr/busy out)
// Parameters: NUM_CH (1..8), CH_BASE (12-bit Address[15:4] match per channel),
//   CH_WAIT (4-bit wait-state count per channel), TIMEOUT_CYCLES (1..255).
// Optional feature: define IO_BUS_TIMEOUT_EN to add the NOMATCH/ERR timeout path;
//   without it, unmatched accesses are ignored and o_berr_l is tied high.
module io_bus_decoder #(
  parameter int                   NUM_CH         = 4,
  parameter logic [12*NUM_CH-1:0] CH_BASE        = {12'h805, 12'h804, 12'h803, 12'h802},
  parameter logic [4*NUM_CH-1:0]  CH_WAIT        = {4'd0, 4'd1, 4'd3, 4'd2},
  parameter int                   TIMEOUT_CYCLES = 16
) (
  input logic             i_clk,
  input logic             i_rst_n,
  io_bus_decoder_if.slave bus
);
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  // One counter serves both wait states (4 bits) and the timeout load value.
  localparam int CNT_W = TIMEOUT_CYCLES > 16 ? $clog2(TIMEOUT_CYCLES) : 4;
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK
`ifdef IO_BUS_TIMEOUT_EN
    , NOMATCH,
    ERR
`endif
  } state_t;
  state_t            r_state;
  logic [NUM_CH-1:0] r_enable;
  logic              r_dtack_l;
  logic              r_busy;
  logic              r_armed;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_cycle;
  logic              w_hit;
  logic [CH_W-1:0]   w_ch;
  logic [CNT_W-1:0]  w_wait;
  logic              w_unused;
  assign w_cycle = bus.i_io_select_h & ~bus.i_as_l;
  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_cycle && bus.i_address[15:4] == CH_BASE[12*i +: 12]) begin
        w_hit = 1'b1;
        w_ch  = CH_W'(i);
      end
  end
  assign w_wait   = CNT_W'(CH_WAIT[4*w_ch +: 4]);
  assign w_unused = &{1'b0, bus.i_address[31:16], bus.i_address[3:0]};
  assign bus.o_enable_h = r_enable;
  assign bus.o_dtack_l  = r_dtack_l;
  assign bus.o_busy_h   = r_busy;
`ifdef IO_BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  logic r_berr_l;
  assign bus.o_berr_l = r_berr_l;
`else
  assign bus.o_berr_l = 1'b1;
`endif
  // r_armed records that AS_L has been seen high since the last access, so a
  // strobe held low across an abort or reset cannot start a second access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_enable  <= '0;
      r_dtack_l <= 1'b1;
      r_busy    <= 1'b0;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
`ifdef IO_BUS_TIMEOUT_EN
      r_berr_l  <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (r_armed && w_hit) begin
            r_state  <= WAIT;
            r_enable <= NUM_CH'(1) << w_ch;
            r_cnt    <= w_wait;
            r_busy   <= 1'b1;
            r_armed  <= 1'b0;
          end
`ifdef IO_BUS_TIMEOUT_EN
          else if (r_armed && w_cycle) begin
            r_state <= NOMATCH;
            r_cnt   <= TO_LOAD;
            r_busy  <= 1'b1;
            r_armed <= 1'b0;
          end
`endif
          else r_armed <= r_armed | bus.i_as_l;
        end
        WAIT: begin
          if (bus.i_as_l) begin
            r_state  <= IDLE;
            r_enable <= '0;
            r_busy   <= 1'b0;
            r_armed  <= 1'b1;
            r_cnt    <= '0;
          end else if (r_cnt == '0) begin
            r_state   <= ACK;
            r_dtack_l <= 1'b0;
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        ACK: begin
          if (bus.i_as_l) begin
            r_state   <= IDLE;
            r_enable  <= '0;
            r_dtack_l <= 1'b1;
            r_busy    <= 1'b0;
            r_armed   <= 1'b1;
          end
        end
`ifdef IO_BUS_TIMEOUT_EN
        NOMATCH: begin
          if (bus.i_as_l) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_armed <= 1'b1;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_state  <= ERR;
            r_berr_l <= 1'b0;
          end else r_cnt <= r_cnt - CNT_W'(1);
        end
        ERR: begin
          if (bus.i_as_l) begin
            r_state  <= IDLE;
            r_berr_l <= 1'b1;
            r_busy   <= 1'b0;
            r_armed  <= 1'b1;
          end
        end
`endif
        default: begin
          r_state   <= IDLE;
          r_enable  <= '0;
          r_dtack_l <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_io_bus_decoder.sv
// tb_io_bus_decoder: directed table-driven bench for io_bus_decoder with default parameters.
module tb_io_bus_decoder;
`ifdef IO_BUS_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  localparam logic [31:0] A0  = 32'h0040_8024;
  localparam logic [31:0] A0N = 32'h1240_802F;
  localparam logic [31:0] A1  = 32'h0040_8034;
  localparam logic [31:0] A2  = 32'h0040_8044;
  localparam logic [31:0] A3  = 32'h0040_8054;
  localparam logic [31:0] AX  = 32'h0040_80F0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  io_bus_decoder_if #(.NUM_CH(4)) bus ();
  io_bus_decoder dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        sel;
    logic        as_l;
    logic [3:0]  en;
    logic        dt;
    logic        be;
    logic        busy;
  } vec_t;
  vec_t tbl[$];
  function automatic void v(input string nm, input logic [31:0] a, input logic s, input logic as_l,
                            input logic [3:0] en, input logic dt, input logic busy);
    tbl.push_back('{nm, a, s, as_l, en, dt, 1'b1, busy});
  endfunction
  task automatic check(input string nm, input logic [3:0] en, input logic dt, input logic be, input logic busy);
    n_vec++;
    if ({bus.o_enable_h, bus.o_dtack_l, bus.o_berr_l, bus.o_busy_h} !== {en, dt, be, busy}) begin
      n_bad++;
      $display("FAIL %s: got en=%b dtack=%b berr=%b busy=%b, want en=%b dtack=%b berr=%b busy=%b",
               nm, bus.o_enable_h, bus.o_dtack_l, bus.o_berr_l, bus.o_busy_h, en, dt, be, busy);
    end
  endtask
  task automatic step(input logic [31:0] a, input logic s, input logic as_l);
    bus.i_address     = a;
    bus.i_io_select_h = s;
    bus.i_as_l        = as_l;
    @(posedge clk);
    #2;
  endtask
  initial begin
    v("post_reset_no_arm", A0, 1, 0, 4'b0000, 1, 0);
    v("arm",               A0, 1, 1, 4'b0000, 1, 0);
    v("ch0_enter",         A0, 1, 0, 4'b0001, 1, 1);
    v("ch0_wait1",         A0, 1, 0, 4'b0001, 1, 1);
    v("ch0_wait2",         A0, 1, 0, 4'b0001, 1, 1);
    v("ch0_ack",           A0, 1, 0, 4'b0001, 0, 1);
    v("ch0_hold",          A0, 1, 0, 4'b0001, 0, 1);
    v("ch0_release",       A0, 1, 1, 4'b0000, 1, 0);
    v("ch3_enter",         A3, 1, 0, 4'b1000, 1, 1);
    v("ch3_ack",           A3, 1, 0, 4'b1000, 0, 1);
    v("ch3_release",       A3, 1, 1, 4'b0000, 1, 0);
    v("ch1_enter",         A1, 1, 0, 4'b0010, 1, 1);
    v("ch1_wait",          A1, 1, 0, 4'b0010, 1, 1);
    v("ch1_abort",         A1, 1, 1, 4'b0000, 1, 0);
    v("sel_low",           A0, 0, 0, 4'b0000, 1, 0);
    v("sel_low_end",       A0, 0, 1, 4'b0000, 1, 0);
    v("ch2_enter",         A2, 1, 0, 4'b0100, 1, 1);
    v("ch2_addr_change",   A3, 0, 0, 4'b0100, 1, 1);
    v("ch2_ack",           A3, 0, 0, 4'b0100, 0, 1);
    v("ch2_hold",          A3, 0, 0, 4'b0100, 0, 1);
    v("ch2_release",       A3, 0, 1, 4'b0000, 1, 0);
    v("ch0n_enter",        A0N, 1, 0, 4'b0001, 1, 1);
    v("ch0n_wait1",        A0N, 1, 0, 4'b0001, 1, 1);
    v("ch0n_wait2",        A0N, 1, 0, 4'b0001, 1, 1);
    v("ch0n_ack",          A0N, 1, 0, 4'b0001, 0, 1);
    v("ch0n_release",      A0N, 1, 1, 4'b0000, 1, 0);
    bus.i_address     = A0;
    bus.i_io_select_h = 1'b1;
    bus.i_as_l        = 1'b0;
    #12;
    check("reset_values", 4'b0000, 1, 1, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      step(tbl[i].addr, tbl[i].sel, tbl[i].as_l);
      check(tbl[i].name, tbl[i].en, tbl[i].dt, tbl[i].be, tbl[i].busy);
    end
    // Reset during ACK with AS_L held low: no re-entry until the strobe cycles.
    step(A3, 1, 0);
    check("rst_seq_enter", 4'b1000, 1, 1, 1);
    step(A3, 1, 0);
    check("rst_seq_ack", 4'b1000, 0, 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", 4'b0000, 1, 1, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(A3, 1, 0);
      check("rst_no_reentry", 4'b0000, 1, 1, 0);
    end
    step(A3, 1, 1);
    check("rst_rearm", 4'b0000, 1, 1, 0);
    step(A3, 1, 0);
    check("rst_reenter", 4'b1000, 1, 1, 1);
    step(A3, 1, 0);
    check("rst_reack", 4'b1000, 0, 1, 1);
    step(A3, 1, 1);
    check("rst_release", 4'b0000, 1, 1, 0);
    // Unmatched access held for 20 cycles: bus error only when the timeout is built in.
    for (int i = 1; i <= 20; i++) begin
      step(AX, 1, 0);
      check("timeout_cycle", 4'b0000, 1, (TO && i >= 17) ? 1'b0 : 1'b1, TO);
    end
    step(AX, 1, 1);
    check("timeout_release", 4'b0000, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(AX, 1, 0);
      check("nomatch_short", 4'b0000, 1, 1, TO);
    end
    step(AX, 1, 1);
    check("nomatch_abort", 4'b0000, 1, 1, 0);
    step(A0, 1, 0);
    check("after_nomatch_enter", 4'b0001, 1, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
